slot_spi_cmd_rx: RTL and testbench
==================================

Name: slot_spi_cmd_rx

Overview:
Parametrised successor to the slot machine's SPI command path: receives framed commands from the MCU over SPI (mode 0, MSB first), oversampled entirely in the pixel/PLL clock domain. Supports N reels, configurable index and credit widths, per-frame checksum, length/error checking, and a status byte returned on sdo. Drives the reel indices, start_spin, and credit update strobes into the memory controller and score logic. Tracks spin busy/done to gate new spins and drive ready.

Parameters:
NUM_REELS, 3, number of reels; SPIN payload is NUM_REELS bytes (1..8)
IDX_W, 3, reel index width; low IDX_W bits of each payload byte used (1..8)
CREDIT_W, 12, credit width; 2-byte big-endian payload, upper 16-CREDIT_W bits ignored (≤16)
SYNC_STAGES, 2, synchronizer depth for sclk/cs/copi (≥2)

Ports:
clk  in  1  system clock (PLL output); sclk must be ≤ clk/8
reset_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, asynchronous
cs  in  1  SPI chip select, active low, asynchronous
copi  in  1  SPI data in
sdo  out  1  SPI data out (status byte)
spin_done  in  1  one-cycle pulse from memory controller: reel animation finished
reel_idx  out  NUM_REELS*IDX_W  final reel indices, reel 0 in LSBs
start_spin  out  1  one-cycle pulse on accepted SPIN
win_credits  out  CREDIT_W  last accepted win amount
win_valid  out  1  one-cycle pulse on accepted WIN
total_credits  out  CREDIT_W  last accepted total
total_valid  out  1  one-cycle pulse on accepted TOTAL
ready  out  1  high when no spin in progress
err_code  out  2  last frame result: 0 ok, 1 bad length, 2 bad checksum, 3 rejected (busy/unknown opcode)

Behaviour:
- Reset: all outputs 0 except ready=1; sdo=0; FSM IDLE; frame counter 0. Reset mid-frame discards the frame, no strobes.
- Inputs pass through SYNC_STAGES flops; sclk rise/fall and cs fall/rise detected by edge compare on synchronized values.
- Frame = opcode byte, payload bytes, checksum byte (XOR of opcode and all payload bytes).
- Opcodes: 0x01 SPIN (NUM_REELS payload bytes), 0x02 WIN (2), 0x03 TOTAL (2), 0x04 STATUS (0 payload, checksum 0x04).
- FSM: IDLE -> RX on cs fall; RX shifts copi on each sclk rise, bit_cnt 0..7, byte completion stored in frame buffer (max 10 bytes); byte_cnt saturates at 15. RX -> EVAL on cs rise; EVAL (1 cycle) -> IDLE.
- EVAL checks in order: bit_cnt≠0 or byte_cnt≠expected length or unknown opcode -> err 1 (unknown opcode -> 3); checksum mismatch -> 2; SPIN while ready=0 -> 3; else 0 and commit.
- Commit: registers updated and matching strobe pulses in the cycle after EVAL (latency SYNC_STAGES+2 clk from cs rise at pin). Failed frame: no register change, no strobe. err_code updated every EVAL (STATUS included, ok=0).
- ready cleared same cycle as start_spin; set on spin_done. spin_done coincident with start_spin: start wins, ready stays 0. spin_done while ready=1 ignored.
- sdo: on cs fall, load status byte {ready, 1'b0, err_code, frame_cnt[3:0]}; MSB driven immediately, shift on each sclk fall; after 8 bits sdo=0. sdo=0 while cs high.
- frame_cnt: 4-bit count of committed frames, wraps 15->0.
- cs rise with no bytes (byte_cnt 0, bit_cnt 0): ignored, no err update.

Decomposition:
- slot_pkg: opcode constants, err_code enum, status byte field positions, frame length function of NUM_REELS.
- Sub-module spi_sync_edge (SYNC_STAGES synchronizer + rise/fall pulse), one instance per sclk, cs, copi (copi uses level only).

Test Plan:
- SPIN frame 01 00 06 04 03 -> start_spin pulse, reel_idx={4,6,0}=0x130, ready=0, err_code=0; spin_done pulse -> ready=1.
- WIN frame 02 01 2C 2F -> win_credits=0x12C, win_valid pulse once; total unchanged.
- Bad checksum 03 00 10 00 -> err_code=2, total_credits unchanged, no total_valid; next STATUS read shows byte 0x80|(2<<4)|cnt.
- SPIN while busy (no spin_done) -> err_code=3, no start_spin, reel_idx held; short frame 02 01 (cs rise) -> err_code=1.
- cs rise after 5 bits -> err_code=1; 16 committed frames -> frame_cnt wraps to 0 in status byte.
- Assert reset_n low mid-SPIN-frame -> all outputs reset, ready=1, no strobe after release; next valid frame accepted.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared definitions for the slot machine SPI command receiver.
// Opcodes, frame-result codes, FSM states and status byte layout.
package slot_pkg;

    localparam logic [7:0] OP_SPIN   = 8'h01;
    localparam logic [7:0] OP_WIN    = 8'h02;
    localparam logic [7:0] OP_TOTAL  = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;

    localparam int MAX_BYTES = 10;

    localparam int STS_READY  = 7;
    localparam int STS_ERR_LO = 4;
    localparam int STS_CNT_LO = 0;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2,
        ERR_REJ  = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_EVAL
    } state_t;

    // Whole frame length in bytes; zero marks an unknown opcode.
    function automatic logic [3:0] frame_len(input logic [7:0] op,
                                             input int reels);
        case (op)
            OP_SPIN:          frame_len = 4'(reels + 2);
            OP_WIN, OP_TOTAL: frame_len = 4'd4;
            OP_STATUS:        frame_len = 4'd2;
            default:          frame_len = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] status_byte(input logic rdy,
                                               input err_t err,
                                               input logic [3:0] cnt);
        logic [7:0] s;
        s = '0;
        s[STS_READY] = rdy;
        s[STS_ERR_LO +: 2] = err;
        s[STS_CNT_LO +: 4] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin,
// with rise/fall pulses from comparing successive synced values.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/slot_spi_cmd_rx.sv
// SPI command receiver for the slot machine, oversampled in clk domain.
// Frames are opcode, payload, XOR checksum; results drive reels/credits.
module slot_spi_cmd_rx
    import slot_pkg::*;
#(
    parameter int NUM_REELS   = 3,
    parameter int IDX_W       = 3,
    parameter int CREDIT_W    = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sclk,
    input  logic                       cs,
    input  logic                       copi,
    output logic                       sdo,
    input  logic                       spin_done,
    output logic [NUM_REELS*IDX_W-1:0] reel_idx,
    output logic                       start_spin,
    output logic [CREDIT_W-1:0]        win_credits,
    output logic                       win_valid,
    output logic [CREDIT_W-1:0]        total_credits,
    output logic                       total_valid,
    output logic                       ready,
    output logic [1:0]                 err_code
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic copi_level, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset_n(reset_n), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset_n(reset_n), .din(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .reset_n(reset_n), .din(copi),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t     state, state_nx;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic [7:0] shreg;
    logic [7:0] fbuf [MAX_BYTES];
    logic [7:0] sdo_sh;
    logic [3:0] frame_cnt;
    err_t       err_q;
    logic [3:0] exp_len;
    logic [7:0] csum;
    err_t       eval_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // A cs pulse with nothing clocked in is not a frame at all.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (cs_fall) state_nx = ST_RX;
            ST_RX: begin
                if (cs_rise)
                    state_nx = (byte_cnt == 4'd0 && bit_cnt == 3'd0)
                             ? ST_IDLE : ST_EVAL;
            end
            ST_EVAL: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        exp_len = frame_len(fbuf[0], NUM_REELS);
        csum    = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if (4'(i) < exp_len) csum = csum ^ fbuf[i];
        if (bit_cnt != 3'd0)                   eval_err = ERR_LEN;
        else if (exp_len == 4'd0)              eval_err = ERR_REJ;
        else if (byte_cnt != exp_len)          eval_err = ERR_LEN;
        else if (csum != 8'h00)                eval_err = ERR_CSUM;
        else if (fbuf[0] == OP_SPIN && !ready) eval_err = ERR_REJ;
        else                                   eval_err = ERR_OK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            shreg         <= '0;
            for (int i = 0; i < MAX_BYTES; i++) fbuf[i] <= '0;
            sdo_sh        <= '0;
            frame_cnt     <= '0;
            err_q         <= ERR_OK;
            reel_idx      <= '0;
            start_spin    <= 1'b0;
            win_credits   <= '0;
            win_valid     <= 1'b0;
            total_credits <= '0;
            total_valid   <= 1'b0;
            ready         <= 1'b1;
        end else begin
            start_spin  <= 1'b0;
            win_valid   <= 1'b0;
            total_valid <= 1'b0;

            if (state == ST_IDLE && cs_fall) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end

            if (state == ST_RX && sclk_rise) begin
                shreg   <= {shreg[6:0], copi_level};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt < 4'(MAX_BYTES))
                        fbuf[byte_cnt] <= {shreg[6:0], copi_level};
                    if (byte_cnt != 4'hF)
                        byte_cnt <= byte_cnt + 4'd1;
                end
            end

            // A spin committed this cycle overrides a late spin_done.
            if (spin_done && !start_spin) ready <= 1'b1;

            if (state == ST_EVAL) begin
                err_q <= eval_err;
                if (eval_err == ERR_OK) begin
                    frame_cnt <= frame_cnt + 4'd1;
                    unique case (1'b1)
                        (fbuf[0] == OP_SPIN): begin
                            for (int i = 0; i < NUM_REELS; i++)
                                reel_idx[i*IDX_W +: IDX_W] <= IDX_W'(fbuf[i+1]);
                            start_spin <= 1'b1;
                            ready      <= 1'b0;
                        end
                        (fbuf[0] == OP_WIN): begin
                            win_credits <= CREDIT_W'({fbuf[1], fbuf[2]});
                            win_valid   <= 1'b1;
                        end
                        (fbuf[0] == OP_TOTAL): begin
                            total_credits <= CREDIT_W'({fbuf[1], fbuf[2]});
                            total_valid   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            if (cs_fall)
                sdo_sh <= status_byte(ready, err_q, frame_cnt);
            else if (sclk_fall && !cs_level)
                sdo_sh <= {sdo_sh[6:0], 1'b0};
        end
    end

    assign sdo      = ~cs_level & sdo_sh[7];
    assign err_code = err_q;

endmodule

// File: tb/tb_slot_spi_cmd_rx.sv
// Randomized and directed bench for slot_spi_cmd_rx.
// A frame-level model predicts registers, strobes and status bytes.
module tb_slot_spi_cmd_rx;

    localparam int NR = 3;
    localparam int IW = 3;
    localparam int CW = 12;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic cs = 1'b1;
    logic copi = 1'b0;
    logic spin_done = 1'b0;
    logic sdo, start_spin, win_valid, total_valid, ready;
    logic [NR*IW-1:0] reel_idx;
    logic [CW-1:0] win_credits, total_credits;
    logic [1:0] err_code;

    slot_spi_cmd_rx #(
        .NUM_REELS(NR), .IDX_W(IW), .CREDIT_W(CW), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs),
        .copi(copi), .sdo(sdo), .spin_done(spin_done),
        .reel_idx(reel_idx), .start_spin(start_spin),
        .win_credits(win_credits), .win_valid(win_valid),
        .total_credits(total_credits), .total_valid(total_valid),
        .ready(ready), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_start = 0, n_win = 0, n_total = 0;
    int e_start = 0, e_win = 0, e_total = 0;

    always @(posedge clk) begin
        if (start_spin) n_start++;
        if (win_valid) n_win++;
        if (total_valid) n_total++;
    end

    logic [7:0] tx [16];
    logic [7:0] rx, exp_status;
    logic m_ready = 1'b1;
    logic [1:0] m_err = 2'd0;
    logic [3:0] m_cnt = 4'd0;
    logic [NR*IW-1:0] m_reel = '0;
    logic [CW-1:0] m_win = '0, m_total = '0;

    function automatic int frame_bytes(input logic [7:0] op);
        case (op)
            8'h01: return NR + 2;
            8'h02, 8'h03: return 4;
            8'h04: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_apply(input int nbits);
        int n, len;
        logic [7:0] x;
        logic [1:0] e;
        n = nbits / 8;
        len = frame_bytes(tx[0]);
        if (nbits % 8 != 0) e = 2'd1;
        else if (len == 0) e = 2'd3;
        else if (n != len) e = 2'd1;
        else begin
            x = 8'h00;
            for (int i = 0; i < n; i++) x ^= tx[i];
            if (x != 8'h00) e = 2'd2;
            else if (tx[0] == 8'h01 && !m_ready) e = 2'd3;
            else e = 2'd0;
        end
        m_err = e;
        if (e == 2'd0) begin
            m_cnt = m_cnt + 4'd1;
            case (tx[0])
                8'h01: begin
                    for (int i = 0; i < NR; i++)
                        m_reel[i*IW +: IW] = tx[i+1] % (1 << IW);
                    m_ready = 1'b0;
                    e_start++;
                end
                8'h02: begin
                    m_win = CW'((tx[1] * 256 + tx[2]) % (1 << CW));
                    e_win++;
                end
                8'h03: begin
                    m_total = CW'((tx[1] * 256 + tx[2]) % (1 << CW));
                    e_total++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic send(input int nbits, input bit raise);
        @(negedge clk);
        exp_status = {m_ready, 1'b0, m_err, m_cnt};
        rx = 8'h00;
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            copi = tx[i/8][7 - i%8];
            #HALF;
            if (i < 8) rx = {rx[6:0], sdo};
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        if (raise) begin
            cs = 1'b1;
            repeat (12) @(negedge clk);
            model_apply(nbits);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        spin_done = 1'b1;
        @(negedge clk);
        spin_done = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || err_code !== 2'd0 || sdo !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl ready=%b err=%0d sdo=%b want 1 0 0",
                     ready, err_code, sdo);
        end
        checks++;
        if (reel_idx !== '0 || win_credits !== '0 || total_credits !== '0) begin
            errors++;
            $display("FAIL reset_regs reel=%h win=%h tot=%h want 0",
                     reel_idx, win_credits, total_credits);
        end
        checks++;
        if (start_spin !== 1'b0 || win_valid !== 1'b0 || total_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b%b%b want 000",
                     start_spin, win_valid, total_valid);
        end
    endtask

    task automatic test_spin();
        tx[0] = 8'h01; tx[1] = 8'h00; tx[2] = 8'h06;
        tx[3] = 8'h04; tx[4] = 8'h03;
        send(40, 1);
        checks++;
        if (reel_idx !== 9'h130 || n_start !== 1 || ready !== 1'b0
            || err_code !== 2'd0) begin
            errors++;
            $display("FAIL spin reel=%h starts=%0d ready=%b err=%0d want 130 1 0 0",
                     reel_idx, n_start, ready, err_code);
        end
        pulse_done();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL spin_done ready=%b want 1", ready);
        end
    endtask

    task automatic test_win();
        tx[0] = 8'h02; tx[1] = 8'h01; tx[2] = 8'h2C; tx[3] = 8'h2F;
        send(32, 1);
        checks++;
        if (win_credits !== 12'h12C || n_win !== 1 || n_total !== 0
            || total_credits !== 12'h000) begin
            errors++;
            $display("FAIL win got=%h wins=%0d tots=%0d total=%h want 12c 1 0 0",
                     win_credits, n_win, n_total, total_credits);
        end
    endtask

    task automatic test_bad_checksum();
        tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h10; tx[3] = 8'h00;
        send(32, 1);
        checks++;
        if (err_code !== 2'd2 || total_credits !== 12'h000 || n_total !== 0) begin
            errors++;
            $display("FAIL bad_csum err=%0d total=%h tots=%0d want 2 0 0",
                     err_code, total_credits, n_total);
        end
        tx[0] = 8'h04; tx[1] = 8'h04;
        send(16, 1);
        checks++;
        if (rx !== 8'hA2) begin
            errors++;
            $display("FAIL status_after_csum got=%h want a2", rx);
        end
    endtask

    task automatic test_busy();
        tx[0] = 8'h01; tx[1] = 8'h01; tx[2] = 8'h02;
        tx[3] = 8'h03; tx[4] = 8'h01;
        send(40, 1);
        checks++;
        if (reel_idx !== 9'h0D1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_first reel=%h ready=%b want 0d1 0",
                     reel_idx, ready);
        end
        tx[1] = 8'h05; tx[2] = 8'h05; tx[3] = 8'h05; tx[4] = 8'h04;
        send(40, 1);
        checks++;
        if (err_code !== 2'd3 || reel_idx !== 9'h0D1 || n_start !== 2) begin
            errors++;
            $display("FAIL busy_reject err=%0d reel=%h starts=%0d want 3 0d1 2",
                     err_code, reel_idx, n_start);
        end
        tx[0] = 8'h02; tx[1] = 8'h01;
        send(16, 1);
        checks++;
        if (err_code !== 2'd1) begin
            errors++;
            $display("FAIL short_frame err=%0d want 1", err_code);
        end
        pulse_done();
    endtask

    task automatic test_partial();
        tx[0] = 8'h04;
        send(5, 1);
        checks++;
        if (err_code !== 2'd1) begin
            errors++;
            $display("FAIL partial_bits err=%0d want 1", err_code);
        end
    endtask

    task automatic test_wrap();
        tx[0] = 8'h04; tx[1] = 8'h04;
        for (int k = 0; k < 16 && m_cnt != 4'd0; k++) send(16, 1);
        send(16, 1);
        checks++;
        if (rx[3:0] !== 4'h0 || rx !== exp_status) begin
            errors++;
            $display("FAIL cnt_wrap status=%h want %h cnt 0", rx, exp_status);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = n_start;
        tx[0] = 8'h01; tx[1] = 8'h00; tx[2] = 8'h06;
        tx[3] = 8'h04; tx[4] = 8'h03;
        send(20, 0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        cs = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        m_ready = 1'b1; m_err = 2'd0; m_cnt = 4'd0;
        m_reel = '0; m_win = '0; m_total = '0;
        checks++;
        if (ready !== 1'b1 || err_code !== 2'd0 || reel_idx !== '0
            || win_credits !== '0 || total_credits !== '0
            || n_start !== s0 || sdo !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid ready=%b err=%0d reel=%h win=%h tot=%h starts=%0d/%0d",
                     ready, err_code, reel_idx, win_credits, total_credits,
                     n_start, s0);
        end
        send(40, 1);
        checks++;
        if (reel_idx !== 9'h130 || n_start !== s0 + 1 || rx !== 8'h80) begin
            errors++;
            $display("FAIL after_reset reel=%h starts=%0d status=%h want 130 %0d 80",
                     reel_idx, n_start, rx, s0 + 1);
        end
        pulse_done();
    endtask

    task automatic test_random();
        int kind, len, nbits;
        logic [7:0] x;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) < 3) pulse_done();
            kind = $urandom_range(0, 9);
            if (kind < 3) tx[0] = 8'h01;
            else if (kind < 5) tx[0] = 8'h02;
            else if (kind < 7) tx[0] = 8'h03;
            else if (kind < 8) tx[0] = 8'h04;
            else tx[0] = 8'($urandom_range(5, 255));
            len = frame_bytes(tx[0]);
            if (len == 0) len = $urandom_range(1, 6);
            x = tx[0];
            for (int i = 1; i < len - 1; i++) begin
                tx[i] = 8'($urandom_range(0, 255));
                x ^= tx[i];
            end
            if (len > 1) tx[len-1] = x;
            if ($urandom_range(0, 9) < 2)
                tx[len-1] ^= 8'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) begin
                tx[len] = 8'($urandom_range(0, 255));
                len++;
            end else if ($urandom_range(0, 9) == 0 && len > 1) begin
                len--;
            end
            nbits = len * 8;
            if (frame_bytes(tx[0]) != 0 && $urandom_range(0, 9) == 0)
                nbits -= $urandom_range(1, 7);
            send(nbits, 1);
            checks++;
            if (err_code !== m_err || ready !== m_ready) begin
                errors++;
                $display("FAIL rnd%0d_err err=%0d ready=%b want %0d %b",
                         f, err_code, ready, m_err, m_ready);
            end
            checks++;
            if (reel_idx !== m_reel || win_credits !== m_win
                || total_credits !== m_total) begin
                errors++;
                $display("FAIL rnd%0d_regs reel=%h win=%h tot=%h want %h %h %h",
                         f, reel_idx, win_credits, total_credits,
                         m_reel, m_win, m_total);
            end
            checks++;
            if (n_start !== e_start || n_win !== e_win || n_total !== e_total) begin
                errors++;
                $display("FAIL rnd%0d_strobes %0d/%0d/%0d want %0d/%0d/%0d",
                         f, n_start, n_win, n_total, e_start, e_win, e_total);
            end
            if (nbits >= 8) begin
                checks++;
                if (rx !== exp_status) begin
                    errors++;
                    $display("FAIL rnd%0d_status got=%h want %h",
                             f, rx, exp_status);
                end
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) tx[i] = 8'h00;
        test_reset();
        test_spin();
        test_win();
        test_bad_checksum();
        test_busy();
        test_partial();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
